// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor (a - b), LSB first,
//               with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_sr;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_d;
    logic               w_br_nxt;
    logic [WIDTH-1:0]   w_sr_nxt;

    // Single full-subtractor cell on the current LSBs
    assign w_d      = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_sr_nxt = {w_d, r_sr[WIDTH-1:1]};

    assign busy = (r_state != c_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_sa       <= '0;
            r_sb       <= '0;
            r_sr       <= '0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_sr    <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_br  <= w_br_nxt;
                    r_sr  <= w_sr_nxt;
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    // Publish the result with the bit computed on this same edge
                    if (r_cnt == c_LAST) begin
                        diff       <= w_sr_nxt;
                        borrow_out <= w_br_nxt;
                        done       <= 1'b1;
                        r_state    <= c_DONE;
                    end
                end
                c_DONE: begin
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor (8-bit and
//               exhaustive 4-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;

    int n_checks;
    int n_pass;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] exp_d, input logic exp_b);
        int cyc;
        int busy_cnt;
        logic stable;
        logic [7:0] d0;
        d0     = diff;
        stable = 1'b1;
        a = va; b = vb; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va; b = ~vb;
        busy_cnt = busy ? 1 : 0;
        cyc = 0;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
            if (done) break;
            if (diff !== d0) stable = 1'b0;
        end
        check($sformatf("latency %02h-%02h", va, vb), cyc, 8);
        check($sformatf("diff %02h-%02h", va, vb), diff, exp_d);
        check($sformatf("borrow %02h-%02h", va, vb), borrow_out, exp_b);
        check($sformatf("stable %02h-%02h", va, vb), stable, 1);
        check($sformatf("busy_cycles %02h-%02h", va, vb), busy_cnt, 9);
        tick();
        check($sformatf("idle %02h-%02h", va, vb), {busy, done}, 2'b00);
    endtask

    initial begin
        int cyc;
        int ndone;
        int last_done;
        logic ok;

        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #12;
        check("reset_outputs", {busy, done, diff, borrow_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(8'h5A, 8'h23, 8'h37, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1);
        run_op(8'h00, 8'hFF, 8'h01, 1'b1);
        run_op(8'hFF, 8'h01, 8'hFE, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0);

        // start during RUN must be ignored; inputs changed after acceptance
        a = 8'h80; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0; a = 8'hC3; b = 8'h5E;
        tick(); tick();
        a = 8'h00; b = 8'h00; start = 1'b1;
        tick();
        start = 1'b0; a = 8'hAA; b = 8'h55;
        ndone = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ndone++;
                if (diff == 8'h7F && borrow_out == 1'b0) ok = 1'b1;
            end
            tick();
        end
        check("midrun_done_count", ndone, 1);
        check("midrun_result", ok, 1);
        check("midrun_idle", busy, 0);

        // Asynchronous reset mid-operation
        run_op(8'h09, 8'h03, 8'h06, 1'b0);
        a = 8'h50; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #2;
        check("async_reset_outputs", {busy, done, diff, borrow_out}, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("no_done_after_reset", ndone, 0);
        run_op(8'h09, 8'h03, 8'h06, 1'b0);

        // Continuous start: back-to-back ops every WIDTH+2 cycles
        a = 8'h33; b = 8'h11; start = 1'b1;
        ndone = 0; last_done = -1; ok = 1'b1;
        for (int idx = 0; idx < 32; idx++) begin
            tick();
            if (done) begin
                if (diff !== 8'h22 || borrow_out !== 1'b0) ok = 1'b0;
                if (ndone == 0) check("hold_first_done", idx, 8);
                else check("hold_period", idx - last_done, 10);
                last_done = idx;
                ndone++;
            end
        end
        start = 1'b0;
        check("hold_done_count", ndone, 3);
        check("hold_results", ok, 1);
        cyc = 0;
        while (busy && cyc < 20) begin
            tick();
            cyc++;
        end
        check("hold_drain", busy, 0);

        // Exhaustive 4-bit instance
        ok = 1'b1;
        for (int va = 0; va < 16; va++) begin
            for (int vb = 0; vb < 16; vb++) begin
                int ed;
                a4 = 4'(va); b4 = 4'(vb); start4 = 1'b1;
                tick();
                start4 = 1'b0;
                cyc = 0;
                while (!done4 && cyc < 10) begin
                    tick();
                    cyc++;
                end
                ed = (va - vb) & 15;
                check($sformatf("w4 %0d-%0d", va, vb), {cyc[3:0], borrow4, diff4},
                      {4'd4, (va < vb) ? 1'b1 : 1'b0, 4'(ed)});
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
